// File: rtl/vector_frame_sched.sv
// Frame scheduler for the vector display engine: walks the enabled display-list
// sources in priority order each refresh tick, launching one list at a time.
module vector_frame_sched #(
    parameter int NSRC         = 4,
    parameter int ADDRESSWIDTH = 16,
    parameter int TIMEOUT      = 65536
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic [NSRC-1:0]              src_en,
    input  logic [NSRC*ADDRESSWIDTH-1:0] src_base,
    input  logic                         halt_flag,
    output logic                         go_flag,
    output logic [ADDRESSWIDTH-1:0]      start_addr,
    output logic [$clog2(NSRC)-1:0]      cur_src,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun,
    output logic                         timeout_err
);

    localparam int IW = $clog2(NSRC);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] LAST_SRC = IW'(NSRC - 1);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [NSRC-1:0]         en_q, en_q_nxt;
    logic [TW-1:0]           timer, timer_nxt;
    logic                    go_nxt, busy_nxt, done_nxt, overrun_nxt, tmo_nxt;
    logic [ADDRESSWIDTH-1:0] start_nxt;
    logic [IW-1:0]           cur_nxt;

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        en_q_nxt    = en_q;
        timer_nxt   = timer;
        go_nxt      = 1'b0;
        start_nxt   = start_addr;
        cur_nxt     = cur_src;
        done_nxt    = 1'b0;
        tmo_nxt     = 1'b0;
        overrun_nxt = overrun | (frame_tick && (state != IDLE));

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    en_q_nxt  = src_en;
                    idx_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (en_q[idx]) begin
                    start_nxt = src_base[int'(idx)*ADDRESSWIDTH +: ADDRESSWIDTH];
                    cur_nxt   = idx;
                    go_nxt    = 1'b1;
                    timer_nxt = '0;
                    state_nxt = WAIT;
                end else if (idx == LAST_SRC) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            WAIT: begin
                timer_nxt = timer + TW'(1);
                // A halt arriving on the watchdog's last cycle still counts as a clean finish.
                if (halt_flag || (timer == TMAX)) begin
                    tmo_nxt = !halt_flag;
                    if (idx == LAST_SRC) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + IW'(1);
                        state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                // Two cycles here: the first raises frame_done, the second shows it.
                if (frame_done) state_nxt = IDLE;
                else            done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            en_q        <= '0;
            timer       <= '0;
            go_flag     <= 1'b0;
            start_addr  <= '0;
            cur_src     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            en_q        <= en_q_nxt;
            timer       <= timer_nxt;
            go_flag     <= go_nxt;
            start_addr  <= start_nxt;
            cur_src     <= cur_nxt;
            busy        <= busy_nxt;
            frame_done  <= done_nxt;
            overrun     <= overrun_nxt;
            timeout_err <= tmo_nxt;
        end
    end

endmodule

// File: doc/vector_frame_sched.md
# vector_frame_sched

Frame scheduler for the vector display engine. On each refresh tick it walks up to NSRC display-list sources in fixed priority order: map, enemies, missiles, cursor, or the menu set when the game is not running. For each enabled source it issues one go pulse with that list's ROM start address, then waits for the engine's halt before moving on. A watchdog catches a hung engine, and frame overruns are flagged; the engine's xch/ych output is untouched.

## Interface
- NSRC, 4, number of display-list sources (index 0 = highest priority, drawn first)
- ADDRESSWIDTH, 16, ROM address width, same as vector ROM
- TIMEOUT, 65536, max cycles in WAIT before the watchdog fires (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_tick  in  1  one-cycle pulse requesting a new frame
- src_en  in  NSRC  per-source enable, snapshotted at frame start
- src_base  in  NSRC*ADDRESSWIDTH  flattened start addresses, source i at [i*ADDRESSWIDTH +: ADDRESSWIDTH]
- halt_flag  in  1  engine end-of-list pulse
- go_flag  out  1  one-cycle launch pulse to engine
- start_addr  out  ADDRESSWIDTH  list start address, valid from go_flag through end of WAIT
- cur_src  out  $clog2(NSRC)  index of source currently drawn
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at frame end
- overrun  out  1  sticky: frame_tick arrived while busy
- timeout_err  out  1  one-cycle pulse when the watchdog fires

## Operation
- States: IDLE, SCAN, WAIT, DONE. All outputs registered.
- IDLE
  - On frame_tick: en_q <= src_en, idx <= 0, go to SCAN.
- SCAN
  - If en_q[idx]: start_addr <= src_base[idx], cur_src <= idx, go_flag <= 1, timer <= 0, go to WAIT.
  - Else if idx == NSRC-1: go to DONE.
  - Else: idx <= idx+1, stay in SCAN. Each disabled source costs exactly 1 cycle.
- WAIT
  - go_flag is high only on the first WAIT cycle. timer increments every cycle.
  - On halt_flag, or when timer == TIMEOUT-1: if idx == NSRC-1 go to DONE, else idx <= idx+1 and go to SCAN.
  - Timer expiry without halt_flag pulses timeout_err for 1 cycle, coinciding with the exit transition.
- DONE
  - frame_done <= 1 for 1 cycle, then IDLE.
- en_q snapshot: src_en and src_base changes mid-frame do not alter which sources run. start_addr samples src_base at SCAN time.
- frame_tick in any state other than IDLE is ignored and sets overrun. overrun clears only on rst.
- halt_flag outside WAIT is ignored, including in the go_flag cycle's preceding SCAN.
- halt_flag and timeout in the same cycle: halt wins, no timeout_err.
- Reset values: state IDLE, go_flag 0, start_addr 0, cur_src 0, busy 0, frame_done 0, overrun 0, timeout_err 0, idx 0, en_q 0, timer 0.
- rst mid-frame aborts immediately. No frame_done; the engine is not notified.

## Timing
- frame_tick sampled at edge k: SCAN during k+1. If source 0 is enabled, go_flag is high during k+2.
- halt_flag sampled at edge m: SCAN during m+1, next enabled source's go_flag is high during m+2 at the earliest.
- Last source's halt at edge m: DONE during m+1, frame_done high during m+2, IDLE (busy 0) during m+3.
- A frame_tick sampled while frame_done is high is still an overrun; ticks are accepted from the first IDLE cycle.
- Fixed overhead per frame with all sources disabled: 1 IDLE->SCAN cycle + NSRC SCAN cycles + 1 DONE cycle before frame_done.
- Timeout fires with timer == TIMEOUT-1, i.e. TIMEOUT cycles after the go_flag cycle (inclusive).

## Test plan
- All enabled, bases 0x0000/0x0100/0x0200/0x0300, engine model halts 10 cycles after each go. Required:
  - 4 go_flag pulses with those start_addr values and cur_src 0..3 in order.
  - Consecutive go_flag pulses spaced 12 cycles apart.
  - frame_done 2 cycles after the 4th halt; no timeout_err.
- src_en=4'b0101. Required:
  - Exactly 2 go_flag pulses, addresses of sources 0 and 2.
  - Source 2's go_flag occurs 3 cycles after source 0's halt (one skip cycle).
- src_en=0, tick at edge k. Required: no go_flag, frame_done high during k+6 (NSRC=4), busy high k+1..k+6.
- TIMEOUT=32, engine never halts, src_en=4'b0001. Required: timeout_err pulse 32 cycles after go_flag, then frame_done; a second frame runs normally.
- Tick during WAIT, plus src_en toggled mid-frame. Required: overrun goes high and stays high; the frame completes with the original sources; no extra frame starts.
- rst asserted during WAIT. Required: all outputs at reset values the next cycle, no frame_done; the next tick starts a clean frame from source 0.
